// File: rtl/pic_init_sequencer_if.sv
// Chip-side CPU bus of an 8259A-compatible controller: the init sequencer drives it as
// master, the controller's ICW/OCW register decode samples it as slave.
interface pic_init_sequencer_if;
  logic       chip_select_n;
  logic       write_enable_n;
  logic       address;
  logic [7:0] data_out;
  logic       data_out_enable;

  modport master (
    output chip_select_n,
    output write_enable_n,
    output address,
    output data_out,
    output data_out_enable
  );

  modport slave (
    input chip_select_n,
    input write_enable_n,
    input address,
    input data_out,
    input data_out_enable
  );
endinterface

// File: rtl/pic_init_sequencer.sv
// Writes ICW1..ICW4 (optionally OCW1 under OCW1_MASK_EN) to an 8259A; 2+W+R clocks per write.
// No backpressure: start is taken only when idle, busy/done report progress and completion.
module pic_init_sequencer #(
  parameter int WR_PULSE_CYCLES = 2,
  parameter int RECOVERY_CYCLES = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        level_trigger,
  input  logic                        call_interval_4,
  input  logic                        single_mode,
  input  logic                        icw4_needed,
  input  logic [7:0]                  vector_base,
  input  logic [7:0]                  cascade_config,
  input  logic [4:0]                  icw4_bits,
  input  logic [7:0]                  initial_mask,
  output logic                        busy,
  output logic                        done,
  pic_init_sequencer_if.master        bus
);

  localparam int MAX_CYC = (WR_PULSE_CYCLES > RECOVERY_CYCLES) ? WR_PULSE_CYCLES : RECOVERY_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RECOVER, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    W_ICW1, W_ICW2, W_ICW3, W_ICW4, W_OCW1, W_NONE
  } word_t;

  state_t           state;
  word_t            word;
  logic [CNT_W-1:0] cnt;

  logic             cfg_single;
  logic             cfg_ic4;
  logic [7:0]       cfg_vector;
  logic [7:0]       cfg_cascade;
  logic [4:0]       cfg_icw4;
`ifdef OCW1_MASK_EN
  logic [7:0]       cfg_mask;
`else
  logic             unused_mask;
  assign unused_mask = ^initial_mask;
`endif

  word_t            fin_word;
  word_t            nxt_word;
  logic [7:0]       nxt_data;

  // "Finish" is either the optional mask write or the end of the sequence.
`ifdef OCW1_MASK_EN
  assign fin_word = (word == W_OCW1) ? W_NONE : W_OCW1;
`else
  assign fin_word = W_NONE;
`endif

  always_comb begin
    nxt_word = W_NONE;
    nxt_data = 8'h00;
    case (word)
      W_ICW1:  nxt_word = W_ICW2;
      W_ICW2:  nxt_word = !cfg_single ? W_ICW3 : (cfg_ic4 ? W_ICW4 : fin_word);
      W_ICW3:  nxt_word = cfg_ic4 ? W_ICW4 : fin_word;
      W_ICW4:  nxt_word = fin_word;
      W_OCW1:  nxt_word = fin_word;
      default: nxt_word = W_NONE;
    endcase
    case (nxt_word)
      W_ICW2:  nxt_data = cfg_vector;
      W_ICW3:  nxt_data = cfg_cascade;
      W_ICW4:  nxt_data = {3'b000, cfg_icw4};
`ifdef OCW1_MASK_EN
      W_OCW1:  nxt_data = cfg_mask;
`endif
      default: nxt_data = 8'h00;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state               <= S_IDLE;
      word                <= W_ICW1;
      cnt                 <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      cfg_single          <= 1'b0;
      cfg_ic4             <= 1'b0;
      cfg_vector          <= 8'h00;
      cfg_cascade         <= 8'h00;
      cfg_icw4            <= 5'h00;
`ifdef OCW1_MASK_EN
      cfg_mask            <= 8'h00;
`endif
      bus.chip_select_n   <= 1'b1;
      bus.write_enable_n  <= 1'b1;
      bus.address         <= 1'b0;
      bus.data_out        <= 8'h00;
      bus.data_out_enable <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            cfg_single          <= single_mode;
            cfg_ic4             <= icw4_needed;
            cfg_vector          <= vector_base;
            cfg_cascade         <= cascade_config;
            cfg_icw4            <= icw4_bits;
`ifdef OCW1_MASK_EN
            cfg_mask            <= initial_mask;
`endif
            word                <= W_ICW1;
            state               <= S_SETUP;
            cnt                 <= '0;
            busy                <= 1'b1;
            bus.chip_select_n   <= 1'b0;
            bus.data_out_enable <= 1'b1;
            bus.address         <= 1'b0;
            // ICW1 is built straight from the inputs so it is valid in the first SETUP cycle.
            bus.data_out        <= {3'b000, 1'b1, level_trigger, call_interval_4,
                                    single_mode, icw4_needed};
          end
        end
        S_SETUP: begin
          state              <= S_STROBE;
          bus.write_enable_n <= 1'b0;
          cnt                <= CNT_W'(WR_PULSE_CYCLES - 1);
        end
        S_STROBE: begin
          if (cnt == '0) begin
            state              <= S_HOLD;
            bus.write_enable_n <= 1'b1;
            cnt                <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_HOLD: begin
          state               <= S_RECOVER;
          bus.chip_select_n   <= 1'b1;
          bus.data_out_enable <= 1'b0;
          bus.address         <= 1'b0;
          bus.data_out        <= 8'h00;
          cnt                 <= CNT_W'(RECOVERY_CYCLES - 1);
        end
        S_RECOVER: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (nxt_word == W_NONE) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cnt   <= '0;
          end else begin
            word                <= nxt_word;
            state               <= S_SETUP;
            cnt                 <= '0;
            bus.chip_select_n   <= 1'b0;
            bus.data_out_enable <= 1'b1;
            bus.address         <= 1'b1;
            bus.data_out        <= nxt_data;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          cnt   <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pic_init_sequencer.sv
// Directed bench for pic_init_sequencer: default-timing instance plus a W=3/R=1 instance.
module tb_pic_init_sequencer;

`ifdef OCW1_MASK_EN
  localparam int MASK_W = 1;
`else
  localparam int MASK_W = 0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       use_b = 1'b0;
  logic       level_trigger = 1'b0, call_interval_4 = 1'b0, single_mode = 1'b0, icw4_needed = 1'b0;
  logic [7:0] vector_base = 8'h00, cascade_config = 8'h00, initial_mask = 8'h00;
  logic [4:0] icw4_bits = 5'h00;

  logic start_a, start_b, busy_a, busy_b, done_a, done_b;
  assign start_a = start & ~use_b;
  assign start_b = start & use_b;

  pic_init_sequencer_if bus_a ();
  pic_init_sequencer_if bus_b ();

  pic_init_sequencer u_dut_a (
    .clock(clock), .reset(reset), .start(start_a),
    .level_trigger(level_trigger), .call_interval_4(call_interval_4),
    .single_mode(single_mode), .icw4_needed(icw4_needed),
    .vector_base(vector_base), .cascade_config(cascade_config),
    .icw4_bits(icw4_bits), .initial_mask(initial_mask),
    .busy(busy_a), .done(done_a), .bus(bus_a.master)
  );

  pic_init_sequencer #(.WR_PULSE_CYCLES(3), .RECOVERY_CYCLES(1)) u_dut_b (
    .clock(clock), .reset(reset), .start(start_b),
    .level_trigger(level_trigger), .call_interval_4(call_interval_4),
    .single_mode(single_mode), .icw4_needed(icw4_needed),
    .vector_base(vector_base), .cascade_config(cascade_config),
    .icw4_bits(icw4_bits), .initial_mask(initial_mask),
    .busy(busy_b), .done(done_b), .bus(bus_b.master)
  );

  always #5 clock = ~clock;

  logic       m_cs, m_we, m_addr, m_oe, m_busy, m_done;
  logic [7:0] m_data;
  assign m_cs   = use_b ? bus_b.chip_select_n   : bus_a.chip_select_n;
  assign m_we   = use_b ? bus_b.write_enable_n  : bus_a.write_enable_n;
  assign m_addr = use_b ? bus_b.address         : bus_a.address;
  assign m_data = use_b ? bus_b.data_out        : bus_a.data_out;
  assign m_oe   = use_b ? bus_b.data_out_enable : bus_a.data_out_enable;
  assign m_busy = use_b ? busy_b : busy_a;
  assign m_done = use_b ? done_b : done_a;

  int n_checks = 0;
  int n_fail   = 0;

  // Bus observer on the selected instance: write log, strobe widths, CS gaps, window stability.
  logic [8:0] wq[$];
  int         wr_runs[$];
  int         cs_gaps[$];
  int         done_total = 0, stab_err = 0, oe_err = 0;
  int         we_run = 0, cs_gap = 0;
  logic       we_prev = 1'b1, cs_prev = 1'b1;
  logic [8:0] win = 9'h000;

  always @(negedge clock) begin
    if (m_done) done_total++;
    if (!m_we && we_prev) wq.push_back({m_addr, m_data});
    if (!m_we) we_run++;
    else if (!we_prev) begin wr_runs.push_back(we_run); we_run = 0; end
    if (m_cs && m_busy) cs_gap++;
    else if (!m_cs && cs_prev && m_busy && cs_gap > 0) begin cs_gaps.push_back(cs_gap); cs_gap = 0; end
    else if (!m_busy) cs_gap = 0;
    if (!m_cs) begin
      if (cs_prev) win = {m_addr, m_data};
      else if ({m_addr, m_data} !== win) stab_err++;
    end
    if (m_oe !== !m_cs) oe_err++;
    we_prev = m_we;
    cs_prev = m_cs;
  end

  task automatic set_cfg(input logic ltim, input logic adi, input logic sngl, input logic ic4,
                         input logic [7:0] vec, input logic [7:0] cas, input logic [4:0] i4,
                         input logic [7:0] mask);
    level_trigger = ltim; call_interval_4 = adi; single_mode = sngl; icw4_needed = ic4;
    vector_base = vec; cascade_config = cas; icw4_bits = i4; initial_mask = mask;
  endtask

  // Pulses start, then counts busy cycles and done cycles until the cycle after done.
  task automatic run_seq(input int glitch_at, output int busy_len, output int done_len, output bit seen);
    busy_len = 0; done_len = 0; seen = 1'b0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (i == glitch_at) begin start = 1'b1; vector_base = 8'hFF; end
      else if (i == glitch_at + 1) start = 1'b0;
      if (m_busy) busy_len++;
      if (m_done) begin done_len++; seen = 1'b1; end
      else if (seen) break;
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++; if (bus_a.chip_select_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n: got %b want 1", bus_a.chip_select_n); end
    n_checks++; if (bus_a.write_enable_n !== 1'b1) begin n_fail++; $display("FAIL reset_we_n: got %b want 1", bus_a.write_enable_n); end
    n_checks++; if (bus_a.address !== 1'b0) begin n_fail++; $display("FAIL reset_a0: got %b want 0", bus_a.address); end
    n_checks++; if (bus_a.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", bus_a.data_out); end
    n_checks++; if (bus_a.data_out_enable !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b want 0", bus_a.data_out_enable); end
    n_checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %b%b want 00", busy_a, done_a); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_single_no_icw4;
    int b, d, base; bit seen;
    set_cfg(1'b0, 1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 5'h00, 8'h5A);
    base = wq.size();
    run_seq(-10, b, d, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL single_done_timeout: got no done want done"); end
    n_checks++; if (wq.size() - base != 2 + MASK_W) begin n_fail++; $display("FAIL single_nwrites: got %0d want %0d", wq.size() - base, 2 + MASK_W); end
    n_checks++; if (wq[base] !== 9'h012) begin n_fail++; $display("FAIL single_icw1: got %h want 012", wq[base]); end
    n_checks++; if (wq[base+1] !== 9'h120) begin n_fail++; $display("FAIL single_icw2: got %h want 120", wq[base+1]); end
    if (MASK_W == 1) begin
      n_checks++; if (wq[base+2] !== 9'h15A) begin n_fail++; $display("FAIL single_ocw1: got %h want 15A", wq[base+2]); end
    end
    n_checks++; if (b != (2 + MASK_W) * 8) begin n_fail++; $display("FAIL single_busy_len: got %0d want %0d", b, (2 + MASK_W) * 8); end
    n_checks++; if (d != 1) begin n_fail++; $display("FAIL single_done_len: got %0d want 1", d); end
  endtask

  task automatic test_cascade_full;
    int b, d, base; bit seen;
    logic [8:0] exp_w [4];
    exp_w = '{9'h019, 9'h108, 9'h104, 9'h101};
    set_cfg(1'b1, 1'b0, 1'b0, 1'b1, 8'h08, 8'h04, 5'h01, 8'hFB);
    base = wq.size();
    run_seq(-10, b, d, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL cascade_done_timeout: got no done want done"); end
    n_checks++; if (wq.size() - base != 4 + MASK_W) begin n_fail++; $display("FAIL cascade_nwrites: got %0d want %0d", wq.size() - base, 4 + MASK_W); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (wq[base+i] !== exp_w[i]) begin n_fail++; $display("FAIL cascade_word%0d: got %h want %h", i, wq[base+i], exp_w[i]); end
    end
    n_checks++; if (b != (4 + MASK_W) * 8) begin n_fail++; $display("FAIL cascade_busy_len: got %0d want %0d", b, (4 + MASK_W) * 8); end
    n_checks++; if (d != 1) begin n_fail++; $display("FAIL cascade_done_len: got %0d want 1", d); end
    n_checks++; if (oe_err != 0) begin n_fail++; $display("FAIL cascade_oe_tracks_cs: got %0d errors want 0", oe_err); end
  endtask

  task automatic test_input_isolation;
    int b, d, base, d0; bit seen;
    set_cfg(1'b1, 1'b0, 1'b0, 1'b1, 8'h08, 8'h04, 5'h01, 8'hFB);
    base = wq.size();
    d0 = done_total;
    run_seq(10, b, d, seen);
    repeat (20) @(negedge clock);
    n_checks++; if (wq.size() - base != 4 + MASK_W) begin n_fail++; $display("FAIL iso_nwrites: got %0d want %0d", wq.size() - base, 4 + MASK_W); end
    n_checks++; if (wq[base] !== 9'h019) begin n_fail++; $display("FAIL iso_icw1: got %h want 019", wq[base]); end
    n_checks++; if (wq[base+1] !== 9'h108) begin n_fail++; $display("FAIL iso_icw2: got %h want 108", wq[base+1]); end
    n_checks++; if (done_total - d0 != 1) begin n_fail++; $display("FAIL iso_done_count: got %0d want 1", done_total - d0); end
    n_checks++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL iso_idle_after: got busy=%b want 0", m_busy); end
  endtask

  task automatic test_reset_mid_strobe;
    int b, d, base, d0; bit seen, hit;
    set_cfg(1'b1, 1'b0, 1'b0, 1'b1, 8'h08, 8'h04, 5'h01, 8'hFB);
    hit = 1'b0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (!m_we && m_addr) hit = 1'b1;
      else @(negedge clock);
    end
    n_checks++; if (!hit) begin n_fail++; $display("FAIL rst_find_icw2_strobe: got none want strobe"); end
    d0 = done_total;
    reset = 1'b1;
    #1;
    n_checks++; if (bus_a.chip_select_n !== 1'b1 || bus_a.write_enable_n !== 1'b1) begin n_fail++; $display("FAIL rst_async_cs_we: got %b%b want 11", bus_a.chip_select_n, bus_a.write_enable_n); end
    n_checks++; if (bus_a.data_out !== 8'h00 || bus_a.data_out_enable !== 1'b0 || bus_a.address !== 1'b0) begin n_fail++; $display("FAIL rst_async_bus: got a0=%b d=%h oe=%b want 0/00/0", bus_a.address, bus_a.data_out, bus_a.data_out_enable); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy: got %b want 0", busy_a); end
    @(negedge clock); reset = 1'b0;
    repeat (12) @(negedge clock);
    n_checks++; if (done_total != d0) begin n_fail++; $display("FAIL rst_no_done: got %0d dones want 0", done_total - d0); end
    base = wq.size();
    run_seq(-10, b, d, seen);
    n_checks++; if (wq.size() - base != 4 + MASK_W) begin n_fail++; $display("FAIL rst_rerun_nwrites: got %0d want %0d", wq.size() - base, 4 + MASK_W); end
    n_checks++; if (wq[base] !== 9'h019) begin n_fail++; $display("FAIL rst_rerun_icw1: got %h want 019", wq[base]); end
    n_checks++; if (d != 1) begin n_fail++; $display("FAIL rst_rerun_done: got %0d want 1", d); end
  endtask

  task automatic test_nondefault_timing;
    int b, d, base, rb, gb, s0; bit seen;
    use_b = 1'b1;
    set_cfg(1'b1, 1'b0, 1'b0, 1'b1, 8'h08, 8'h04, 5'h01, 8'hFB);
    repeat (2) @(negedge clock);
    base = wq.size(); rb = wr_runs.size(); gb = cs_gaps.size(); s0 = stab_err;
    run_seq(-10, b, d, seen);
    n_checks++; if (b != (4 + MASK_W) * 6) begin n_fail++; $display("FAIL timing_busy_len: got %0d want %0d", b, (4 + MASK_W) * 6); end
    n_checks++; if (wr_runs.size() - rb != 4 + MASK_W) begin n_fail++; $display("FAIL timing_nstrobes: got %0d want %0d", wr_runs.size() - rb, 4 + MASK_W); end
    for (int i = rb; i < wr_runs.size(); i++) begin
      n_checks++; if (wr_runs[i] != 3) begin n_fail++; $display("FAIL timing_wr_width%0d: got %0d want 3", i - rb, wr_runs[i]); end
    end
    n_checks++; if (cs_gaps.size() - gb != 3 + MASK_W) begin n_fail++; $display("FAIL timing_ngaps: got %0d want %0d", cs_gaps.size() - gb, 3 + MASK_W); end
    for (int i = gb; i < cs_gaps.size(); i++) begin
      n_checks++; if (cs_gaps[i] != 1) begin n_fail++; $display("FAIL timing_cs_gap%0d: got %0d want 1", i - gb, cs_gaps[i]); end
    end
    n_checks++; if (stab_err != s0) begin n_fail++; $display("FAIL timing_window_stable: got %0d changes want 0", stab_err - s0); end
    n_checks++; if (wq[base+3] !== 9'h101) begin n_fail++; $display("FAIL timing_icw4: got %h want 101", wq[base+3]); end
    use_b = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_mask;
    int b, d, base; bit seen;
    set_cfg(1'b1, 1'b0, 1'b0, 1'b1, 8'h08, 8'h04, 5'h01, 8'hFB);
    base = wq.size();
    run_seq(-10, b, d, seen);
    n_checks++; if (wq.size() - base != 4 + MASK_W) begin n_fail++; $display("FAIL mask_nwrites: got %0d want %0d", wq.size() - base, 4 + MASK_W); end
    n_checks++; if (b != (4 + MASK_W) * 8) begin n_fail++; $display("FAIL mask_busy_len: got %0d want %0d", b, (4 + MASK_W) * 8); end
    if (MASK_W == 1) begin
      n_checks++; if (wq[base+4] !== 9'h1FB) begin n_fail++; $display("FAIL mask_ocw1: got %h want 1FB", wq[base+4]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_no_icw4();
    test_cascade_full();
    test_input_isolation();
    test_reset_mid_strobe();
    test_nondefault_timing();
    test_mask();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pic_init_sequencer.md
# pic_init_sequencer

Host-side initiator that programs an 8259A-compatible interrupt controller. On a `start` pulse it drives the chip's CPU bus (`chip_select_n`, `write_enable_n`, `address`, and a data byte) through the ICW1 → ICW2 → [ICW3] → [ICW4] write sequence. It sits on the bus-master side of the same interface the controller's ICW registers decode. It enforces write-strobe width and inter-write recovery time, and reports completion with a busy/done handshake.

## Interface
- `WR_PULSE_CYCLES`, default 2: `write_enable_n` low width in clocks; legal range ≥1.
- `RECOVERY_CYCLES`, default 4: `chip_select_n` high gap after each write; legal range ≥1.
- `clock`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; accepted only in IDLE.
- `level_trigger`  in  1  ICW1 LTIM (D3).
- `call_interval_4`  in  1  ICW1 ADI (D2).
- `single_mode`  in  1  ICW1 SNGL (D1); 1 skips ICW3.
- `icw4_needed`  in  1  ICW1 IC4 (D0); 0 skips ICW4.
- `vector_base`  in  8  ICW2 byte.
- `cascade_config`  in  8  ICW3 byte.
- `icw4_bits`  in  5  ICW4 D4:D0 = {SFNM, BUF, M/S, AEOI, uPM}.
- `initial_mask`  in  8  OCW1 byte; used only with `OCW1_MASK_EN`.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle completion pulse.
- `chip_select_n`  out  1  active-low chip select.
- `write_enable_n`  out  1  active-low write strobe.
- `address`  out  1  A0.
- `data_out`  out  8  write data.
- `data_out_enable`  out  1  data driver enable; high while `chip_select_n` is low.

## Operation
- Reset values: `chip_select_n`=1, `write_enable_n`=1, `address`=0, `data_out`=0x00, `data_out_enable`=0, `busy`=0, `done`=0.
- **Start.** At the accepting edge, all config inputs are latched into internal registers. Input changes after that edge have no effect until the next start. `start` while `busy`=1 or in DONE is ignored.
- **Word encoding:**
  - ICW1 = {3'b000, 1'b1, LTIM, ADI, SNGL, IC4}, A0=0.
  - ICW2 = `vector_base`, A0=1.
  - ICW3 = `cascade_config`, A0=1.
  - ICW4 = {3'b000, `icw4_bits`}, A0=1.
  - OCW1 = `initial_mask`, A0=1.
- **Word order.** ICW1 → ICW2. After ICW2: ICW3 if SNGL=0, else ICW4 if IC4=1, else finish. After ICW3: ICW4 if IC4=1, else finish. "Finish" means OCW1 when the macro is enabled, otherwise DONE.
- **Bus-cycle FSM:**
  - IDLE: on accepted `start` → SETUP; word = ICW1.
  - SETUP (1 cycle): CS low, OE high, A0/data valid, WR high → STROBE.
  - STROBE (`WR_PULSE_CYCLES` cycles): WR low → HOLD.
  - HOLD (1 cycle): WR high, CS low, data held → RECOVER.
  - RECOVER (`RECOVERY_CYCLES` cycles): CS high, OE low, `data_out`=0. Then → SETUP of the next word, or → DONE after the last word.
  - DONE (1 cycle): `done`=1, `busy`=0 → IDLE.
- `busy`=1 in SETUP, STROBE, HOLD and RECOVER; 0 otherwise.
- `address` and `data_out` are constant across the whole CS-low window (SETUP through HOLD).
- Cycle counter width is `$clog2(max(WR_PULSE_CYCLES, RECOVERY_CYCLES)+1)`. The counter reloads on every state entry.
- **Reset mid-operation:** all outputs return to reset values immediately (async). No `done` pulse. The partial sequence is abandoned; the next start begins at ICW1.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Per write: 2 + `WR_PULSE_CYCLES` + `RECOVERY_CYCLES` clocks (8 at defaults).
- The first SETUP cycle follows the accepting edge.
- With N writes, `busy` is high for N×(2+W+R) cycles. `done` is asserted in the next cycle.
- A new `start` is accepted no earlier than the cycle after DONE.

## Configuration
- `OCW1_MASK_EN` defined: after the last ICW, one additional write of OCW1 (`initial_mask`, A0=1) is issued, with identical bus timing.
- Undefined: the sequence ends after the last ICW; `initial_mask` is present but ignored.

## Test plan
- **Single mode, no ICW4, defaults.** LTIM=0, ADI=0, SNGL=1, IC4=0, `vector_base`=0x20. Expect exactly two writes: A0=0/0x12, then A0=1/0x20. `busy` is high for 16 cycles; `done` pulses for 1 cycle after that.
- **Cascaded master, full sequence.** SNGL=0, IC4=1, LTIM=1, vector 0x08, cascade 0x04, `icw4_bits`=0x01. Expect writes 0x19 (A0=0), 0x08, 0x04, 0x01 (each A0=1). `busy` is high for 32 cycles.
- **Input isolation.** Pulse `start` again during ICW2, and change `vector_base` to 0xFF mid-sequence. The sequence is unaffected, ICW2 data stays 0x08, and exactly one `done` occurs.
- **Reset mid-strobe.** Assert `reset` while WR is low during ICW2. Outputs go idle in the same cycle with no `done`. After release, a new `start` produces a complete sequence beginning with ICW1.
- **Non-default timing.** With `WR_PULSE_CYCLES`=3 and `RECOVERY_CYCLES`=1: WR is low for exactly 3 cycles per write, CS is high for exactly 1 cycle between writes, and data/A0 are stable for the entire CS-low window.
- **Mask macro.** With `OCW1_MASK_EN`, run the scenario-2 setup with `initial_mask`=0xFB: a 5th write, A0=1/0xFB, follows, and `busy` is high for 40 cycles. Without the macro, only 4 writes occur.
